conv_window_gen: RTL

- Downstream consumer of the line-buffer chain: takes three vertically aligned pixel streams and assembles 3x3 convolution windows for the systolic array's input stage.
- Row streams:
  - Oldest row (row 0) comes from the second line buffer.
  - Middle row (row 1) comes from the first line buffer.
  - Newest row (row 2) is the raw pixel stream.
- Beats are qualified by the deepest line buffer's valid, so every accepted beat carries a full 3-row column.
- Tracks column/row position, suppresses windows straddling a row boundary, flags end of frame.

---
 rtl/conv_window_gen.sv | 94 +++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window assembler fed by three vertically aligned row streams.
// Build option: define STRIDE2_EN for stride-2 window emission (default stride-1).
module conv_window_gen #(
  parameter int unsigned WORDWIDTH  = 32,
  parameter int unsigned FIG_WIDTH  = 28,
  parameter int unsigned FIG_HEIGHT = 28,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORDWIDTH-1:0]   row0_din,
  input  logic [WORDWIDTH-1:0]   row1_din,
  input  logic [WORDWIDTH-1:0]   row2_din,
  input  logic                   in_valid,
  output logic [9*WORDWIDTH-1:0] win_dout,
  output logic                   out_valid,
  output logic                   frame_done
);

  // Element (r,c) lives at index 3*r+c in both the shift window and the output.
  logic [8:0][WORDWIDTH-1:0] win_q, win_d;
  logic [8:0][WORDWIDTH-1:0] dout_q, dout_d;
  logic [CNT_WIDTH-1:0]      col_q, col_d;
  logic [CNT_WIDTH-1:0]      row_q, row_d;
  logic                      out_valid_q, out_valid_d;
  logic                      frame_done_q, frame_done_d;

  logic emit;
  logic last_col;
  logic last_row;

  always_comb begin
    win_d        = win_q;
    dout_d       = dout_q;
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    last_col     = (col_q == CNT_WIDTH'(FIG_WIDTH - 1));
    last_row     = (row_q == CNT_WIDTH'(FIG_HEIGHT - 3));
`ifdef STRIDE2_EN
    emit         = (col_q >= CNT_WIDTH'(2)) && !col_q[0] && !row_q[0];
`else
    emit         = (col_q >= CNT_WIDTH'(2));
`endif

    if (in_valid) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = row0_din;
      win_d[5] = row1_din;
      win_d[8] = row2_din;

      if (last_col) begin
        col_d        = '0;
        row_d        = last_row ? '0 : row_q + CNT_WIDTH'(1);
        frame_done_d = last_row;
      end else begin
        col_d = col_q + CNT_WIDTH'(1);
      end

      // Output captures the post-shift window so it includes the current beat.
      if (emit) begin
        out_valid_d = 1'b1;
        dout_d      = win_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q        <= '0;
      dout_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      dout_q       <= dout_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_dout   = dout_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
